// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
// Bundles the pipeline-side signals of hazard_unit into one interface.
//   master : pipeline control (drives ID/EX/stage/long-latency info,
//            receives forward selects, ID stall and EX bubble)
//   slave  : hazard_unit itself
// Signals
//   ex_rs/ex_uses, id_rs/id_uses   source regs (5 bits each) and use flags
//   id_rd/id_wr, ex_rd/ex_wr       destination reg and write enable
//   ex_is_load                     EX instruction is a load
//   stg_rd/stg_wr                  rd and write flag of forwarding stages 1..NUM_FWD
//   mc_issue/mc_rd                 long-latency op leaving ID
//   mc_wb/mc_wb_rd                 long-latency writeback
//   flush                          squash ID/EX
//   fwd_sel/stall_id/bubble_ex     results
// Optional macro HAZARD_PERF_EN adds perf_lu_stalls / perf_sb_stalls.
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2
);
  localparam int SELW = $clog2(NUM_FWD + 1);

  logic [NUM_SRC*5-1:0]    ex_rs;
  logic [NUM_SRC-1:0]      ex_uses;
  logic [NUM_SRC*5-1:0]    id_rs;
  logic [NUM_SRC-1:0]      id_uses;
  logic [4:0]              id_rd;
  logic                    id_wr;
  logic [4:0]              ex_rd;
  logic                    ex_wr;
  logic                    ex_is_load;
  logic [NUM_FWD*5-1:0]    stg_rd;
  logic [NUM_FWD-1:0]      stg_wr;
  logic                    mc_issue;
  logic [4:0]              mc_rd;
  logic                    mc_wb;
  logic [4:0]              mc_wb_rd;
  logic                    flush;
  logic [NUM_SRC*SELW-1:0] fwd_sel;
  logic                    stall_id;
  logic                    bubble_ex;
`ifdef HAZARD_PERF_EN
  logic [31:0]             perf_lu_stalls;
  logic [31:0]             perf_sb_stalls;

  modport master (
    output ex_rs, ex_uses, id_rs, id_uses, id_rd, id_wr, ex_rd, ex_wr,
           ex_is_load, stg_rd, stg_wr, mc_issue, mc_rd, mc_wb, mc_wb_rd, flush,
    input  fwd_sel, stall_id, bubble_ex, perf_lu_stalls, perf_sb_stalls
  );

  modport slave (
    input  ex_rs, ex_uses, id_rs, id_uses, id_rd, id_wr, ex_rd, ex_wr,
           ex_is_load, stg_rd, stg_wr, mc_issue, mc_rd, mc_wb, mc_wb_rd, flush,
    output fwd_sel, stall_id, bubble_ex, perf_lu_stalls, perf_sb_stalls
  );
`else
  modport master (
    output ex_rs, ex_uses, id_rs, id_uses, id_rd, id_wr, ex_rd, ex_wr,
           ex_is_load, stg_rd, stg_wr, mc_issue, mc_rd, mc_wb, mc_wb_rd, flush,
    input  fwd_sel, stall_id, bubble_ex
  );

  modport slave (
    input  ex_rs, ex_uses, id_rs, id_uses, id_rd, id_wr, ex_rd, ex_wr,
           ex_is_load, stg_rd, stg_wr, mc_issue, mc_rd, mc_wb, mc_wb_rd, flush,
    output fwd_sel, stall_id, bubble_ex
  );
`endif
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard logic beside the ID/EX registers:
//   - per-operand forward selects for the EX instruction (0 = regfile,
//     k = forwarding stage k, nearest stage wins, x0 never forwards)
//   - load-use stall FSM holding ID for exactly LOAD_LAT cycles
//   - 32-entry pending scoreboard for long-latency (mul/div) results,
//     stalling ID on RAW or WAW against a pending register
// Ports
//   clk  : clock
//   rst  : synchronous reset, active-low; all outputs read 0 while low
//   hif  : hazard_unit_if.slave (pipeline inputs, fwd_sel/stall_id/bubble_ex)
// Optional macro HAZARD_PERF_EN adds saturating 32-bit stall counters
// perf_lu_stalls and perf_sb_stalls on the interface.
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hif
);
  localparam int         SELW   = $clog2(NUM_FWD + 1);
  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t                  state_r;
  logic [1:0]              cnt_r;
  logic [31:0]             pending_r;

  logic [NUM_SRC*SELW-1:0] fwd_sel_s;
  logic                    lu_match_s;
  logic                    lu_hit_s;
  logic                    sb_hit_s;
  logic                    fsm_stall_s;
  logic                    stall_s;
  logic [31:0]             set_mask_s;
  logic [31:0]             clr_mask_s;
  logic [31:0]             pending_nxt_s;

  // Forward select: walk from the oldest stage to the nearest so the nearest match overwrites.
  always_comb begin
    fwd_sel_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD; k >= 1; k--) begin
        fwd_sel_s[SELW*i +: SELW] =
          (hif.stg_wr[k-1] && (hif.stg_rd[5*(k-1) +: 5] != 5'd0) &&
           (hif.stg_rd[5*(k-1) +: 5] == hif.ex_rs[5*i +: 5]) && hif.ex_uses[i])
          ? SELW'(k) : fwd_sel_s[SELW*i +: SELW];
      end
    end
  end

  // Load-use and scoreboard hazard detection for the instruction in ID.
  always_comb begin
    lu_match_s = 1'b0;
    sb_hit_s   = hif.id_wr & pending_r[hif.id_rd];
    for (int i = 0; i < NUM_SRC; i++) begin
      lu_match_s = lu_match_s | (hif.id_uses[i] & (hif.id_rs[5*i +: 5] == hif.ex_rd));
      sb_hit_s   = sb_hit_s   | (hif.id_uses[i] & pending_r[hif.id_rs[5*i +: 5]]);
    end
    lu_hit_s = hif.ex_is_load & hif.ex_wr & (hif.ex_rd != 5'd0) & lu_match_s;
  end

  // FSM stall request: first cycle comes straight from detection, the rest from LU_STALL.
  always_comb begin
    fsm_stall_s = 1'b0;
    case (state_r)
      IDLE:     fsm_stall_s = lu_hit_s & ~hif.flush;
      LU_STALL: fsm_stall_s = 1'b1;
      default:  fsm_stall_s = 1'b0;
    endcase
  end

  // Load-use FSM; cnt holds the stall cycles still owed after the current one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else if (hif.flush) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (lu_hit_s && (LOAD_LAT > 1)) begin
            state_r <= LU_STALL;
            cnt_r   <= LAT_M1;
          end else begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
          end
        end
        LU_STALL: begin
          if (cnt_r == 2'd1) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
          end else begin
            state_r <= LU_STALL;
            cnt_r   <= cnt_r - 2'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

  // Scoreboard next state: OR-ing the set mask after clearing makes issue win over writeback.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (hif.mc_issue && (hif.mc_rd != 5'd0)) begin
      set_mask_s[hif.mc_rd] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (hif.mc_wb) begin
      clr_mask_s[hif.mc_wb_rd] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Pending register; flush leaves it alone because in-flight ops still write back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign stall_s       = rst & ~hif.flush & (fsm_stall_s | sb_hit_s);
  assign hif.stall_id  = stall_s;
  assign hif.bubble_ex = stall_s;
  assign hif.fwd_sel   = rst ? fwd_sel_s : '0;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_r;
  logic [31:0] perf_sb_r;
  logic        lu_cause_s;
  logic        sb_cause_s;

  assign lu_cause_s = rst & ~hif.flush & fsm_stall_s;
  assign sb_cause_s = rst & ~hif.flush & sb_hit_s;

  // Saturating stall-cause counters; both may count in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_lu_r <= 32'd0;
      perf_sb_r <= 32'd0;
    end else begin
      if (lu_cause_s && (perf_lu_r != 32'hFFFF_FFFF)) begin
        perf_lu_r <= perf_lu_r + 32'd1;
      end
      if (sb_cause_s && (perf_sb_r != 32'hFFFF_FFFF)) begin
        perf_sb_r <= perf_sb_r + 32'd1;
      end
    end
  end

  assign hif.perf_lu_stalls = rst ? perf_lu_r : 32'd0;
  assign hif.perf_sb_stalls = rst ? perf_sb_r : 32'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Directed vectors for hazard_unit (NUM_SRC=2, NUM_FWD=2, LOAD_LAT=3).
// The driver applies one vector per cycle and queues the hand-computed
// expectation; a monitor pops and compares mid-cycle.
// ---------------------------------------------------------------------------
module tb_hazard_unit;
  logic clk;
  logic rst;

  hazard_unit_if #(.NUM_SRC(2), .NUM_FWD(2)) hif ();

  hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  typedef struct {
    string       name;
    logic        stall;
    bit          chk_fwd;
    logic [3:0]  fwd;
    bit          chk_perf;
    logic [31:0] lu;
    logic [31:0] sb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    hif.ex_rs      = 10'd0;
    hif.ex_uses    = 2'b00;
    hif.id_rs      = 10'd0;
    hif.id_uses    = 2'b00;
    hif.id_rd      = 5'd0;
    hif.id_wr      = 1'b0;
    hif.ex_rd      = 5'd0;
    hif.ex_wr      = 1'b0;
    hif.ex_is_load = 1'b0;
    hif.stg_rd     = 10'd0;
    hif.stg_wr     = 2'b00;
    hif.mc_issue   = 1'b0;
    hif.mc_rd      = 5'd0;
    hif.mc_wb      = 1'b0;
    hif.mc_wb_rd   = 5'd0;
    hif.flush      = 1'b0;
  endtask

  // Load in EX writing x7, ID operand 1 reads x7 (operand-use mask given).
  task automatic load_use(input logic [1:0] uses);
    hif.ex_is_load = 1'b1;
    hif.ex_wr      = 1'b1;
    hif.ex_rd      = 5'd7;
    hif.id_rs      = {5'd7, 5'd0};
    hif.id_uses    = uses;
  endtask

  task automatic cyc_full(input string nm, input logic stall, input bit chk_fwd,
                          input logic [3:0] fwd, input bit chk_perf,
                          input logic [31:0] lu, input logic [31:0] sb);
    exp_t e;
    e.name = nm; e.stall = stall; e.chk_fwd = chk_fwd; e.fwd = fwd;
    e.chk_perf = chk_perf; e.lu = lu; e.sb = sb;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input logic stall);
    cyc_full(nm, stall, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic cycf(input string nm, input logic stall, input logic [3:0] fwd);
    cyc_full(nm, stall, 1'b1, fwd, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic cycp(input string nm, input logic stall, input logic [31:0] lu,
                      input logic [31:0] sb);
    cyc_full(nm, stall, 1'b0, 4'd0, 1'b1, lu, sb);
  endtask

  // Monitor: compares the DUT against the queued expectation each mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (hif.stall_id !== e.stall) $display("FAIL %s stall_id: got %0b want %0b", e.name, hif.stall_id, e.stall);
        else n_pass++;
        n_checks++;
        if (hif.bubble_ex !== e.stall) $display("FAIL %s bubble_ex: got %0b want %0b", e.name, hif.bubble_ex, e.stall);
        else n_pass++;
        if (e.chk_fwd) begin
          n_checks++;
          if (hif.fwd_sel !== e.fwd) $display("FAIL %s fwd_sel: got %b want %b", e.name, hif.fwd_sel, e.fwd);
          else n_pass++;
        end
`ifdef HAZARD_PERF_EN
        if (e.chk_perf) begin
          n_checks++;
          if (hif.perf_lu_stalls !== e.lu) $display("FAIL %s perf_lu: got %0d want %0d", e.name, hif.perf_lu_stalls, e.lu);
          else n_pass++;
          n_checks++;
          if (hif.perf_sb_stalls !== e.sb) $display("FAIL %s perf_sb: got %0d want %0d", e.name, hif.perf_sb_stalls, e.sb);
          else n_pass++;
        end
`endif
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // Reset: inputs that would forward and stall, outputs must read 0
    hif.stg_rd = {5'd5, 5'd5}; hif.stg_wr = 2'b11;
    hif.ex_rs = {5'd0, 5'd5};  hif.ex_uses = 2'b01;
    load_use(2'b10);
    cycf("rst_hold1", 1'b0, 4'b0000);
    cycf("rst_hold2", 1'b0, 4'b0000);
    rst = 1'b1;
    idle();

    // Forwarding
    hif.stg_rd = {5'd5, 5'd5}; hif.stg_wr = 2'b11;
    hif.ex_rs = {5'd0, 5'd5};  hif.ex_uses = 2'b01;
    cycf("fwd_youngest", 1'b0, 4'b0001);
    hif.stg_wr = 2'b10;
    cycf("fwd_stage2", 1'b0, 4'b0010);
    hif.stg_rd = 10'd0; hif.stg_wr = 2'b11; hif.ex_rs = 10'd0; hif.ex_uses = 2'b11;
    cycf("fwd_x0", 1'b0, 4'b0000);
    hif.stg_rd = {5'd9, 5'd5}; hif.ex_rs = {5'd9, 5'd5};
    cycf("fwd_both", 1'b0, 4'b1001);
    hif.ex_uses = 2'b01;
    cycf("fwd_uses_gate", 1'b0, 4'b0001);
    idle();

    // Load-use, LOAD_LAT=3; forwarding stays live while stalled
    load_use(2'b10);
    cyc("lu_c1", 1'b1);
    hif.ex_is_load = 1'b0;
    hif.stg_rd = {5'd0, 5'd4}; hif.stg_wr = 2'b01; hif.ex_rs = {5'd0, 5'd4}; hif.ex_uses = 2'b01;
    cycf("lu_c2", 1'b1, 4'b0001);
    cycf("lu_c3", 1'b1, 4'b0001);
    cycf("lu_done", 1'b0, 4'b0001);
    idle();
    load_use(2'b01);
    cyc("lu_unused_op", 1'b0);
    hif.ex_rd = 5'd0; hif.id_rs = 10'd0; hif.id_uses = 2'b11;
    cyc("lu_x0", 1'b0);
    idle();
    cyc("lu_no_residual", 1'b0);

    // Flush inside the stall, and flush alongside a fresh hit
    load_use(2'b10);
    cyc("fl_c1", 1'b1);
    hif.ex_is_load = 1'b0; hif.flush = 1'b1;
    cyc("fl_flush", 1'b0);
    hif.flush = 1'b0;
    cyc("fl_after1", 1'b0);
    cyc("fl_after2", 1'b0);
    load_use(2'b10); hif.flush = 1'b1;
    cyc("fl_idle_hit", 1'b0);
    idle();
    cyc("fl_idle_after", 1'b0);

    // Scoreboard RAW
    hif.mc_issue = 1'b1; hif.mc_rd = 5'd10;
    cyc("sb_issue", 1'b0);
    hif.mc_issue = 1'b0; hif.id_rs = {5'd0, 5'd10}; hif.id_uses = 2'b01;
    cyc("sb_raw1", 1'b1);
    cyc("sb_raw2", 1'b1);
    hif.mc_wb = 1'b1; hif.mc_wb_rd = 5'd10;
    cyc("sb_wb", 1'b1);
    hif.mc_wb = 1'b0;
    cyc("sb_clear", 1'b0);
    idle();

    // Issue and writeback of the same reg in one cycle: bit stays set
    hif.mc_issue = 1'b1; hif.mc_rd = 5'd10;
    cyc("sb_iss2", 1'b0);
    hif.mc_wb = 1'b1; hif.mc_wb_rd = 5'd10; hif.id_rs = {5'd0, 5'd10}; hif.id_uses = 2'b01;
    cyc("sb_setwins", 1'b1);
    hif.mc_issue = 1'b0; hif.mc_wb = 1'b0;
    cyc("sb_still", 1'b1);
    hif.mc_wb = 1'b1;
    cyc("sb_wb2", 1'b1);
    hif.mc_wb = 1'b0;
    cyc("sb_clear2", 1'b0);
    idle();

    // x0 is never pending
    hif.mc_issue = 1'b1; hif.mc_rd = 5'd0;
    cyc("sb_iss_x0", 1'b0);
    hif.mc_issue = 1'b0; hif.id_uses = 2'b11; hif.id_wr = 1'b1;
    cyc("sb_x0", 1'b0);
    idle();

    // WAW, and flush does not clear pending
    hif.mc_issue = 1'b1; hif.mc_rd = 5'd12;
    cyc("waw_issue", 1'b0);
    hif.mc_issue = 1'b0; hif.id_wr = 1'b1; hif.id_rd = 5'd12;
    cyc("waw", 1'b1);
    hif.flush = 1'b1;
    cyc("waw_flush", 1'b0);
    hif.flush = 1'b0;
    cyc("waw_kept", 1'b1);
    hif.mc_wb = 1'b1; hif.mc_wb_rd = 5'd12;
    cyc("waw_wb", 1'b1);
    cyc("wb_nonpend", 1'b0);
    hif.mc_wb = 1'b0;
    cyc("waw_clear", 1'b0);
    idle();

    // Reset in the middle of a load-use stall with x3 pending
    hif.mc_issue = 1'b1; hif.mc_rd = 5'd3;
    cyc("rs_issue3", 1'b0);
    hif.mc_issue = 1'b0;
    load_use(2'b10);
    cyc("rs_lu", 1'b1);
    rst = 1'b0;
    idle();
    hif.id_rs = {5'd0, 5'd3}; hif.id_uses = 2'b01;
    cyc("rs_hold", 1'b0);
    rst = 1'b1;
    cycp("rs_released", 1'b0, 32'd0, 32'd0);
    cyc("rs_released2", 1'b0);
    idle();

    // Stall counters after one full load-use stall and a two-cycle scoreboard stall
    load_use(2'b10);
    cyc("pf_lu1", 1'b1);
    hif.ex_is_load = 1'b0;
    cyc("pf_lu2", 1'b1);
    cyc("pf_lu3", 1'b1);
    idle();
    hif.mc_issue = 1'b1; hif.mc_rd = 5'd20;
    cycp("pf_after_lu", 1'b0, 32'd3, 32'd0);
    hif.mc_issue = 1'b0; hif.id_rs = {5'd20, 5'd0}; hif.id_uses = 2'b10;
    cyc("pf_sb1", 1'b1);
    hif.mc_wb = 1'b1; hif.mc_wb_rd = 5'd20;
    cyc("pf_sb2", 1'b1);
    idle();
    cycp("pf_after_sb", 1'b0, 32'd3, 32'd2);

    // Let the monitor drain, bounded
    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) $display("FAIL drain: got %0d queued want 0", q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised successor to the pipeline's forwarding logic.
- Produces per-operand forward selects across NUM_FWD downstream stages for NUM_SRC source operands of the EX instruction.
- Adds a multi-cycle load-use stall FSM and a per-register scoreboard for long-latency (mul/div) ops.
- Sits beside the ID/EX pipeline registers; drives EX operand muxes, ID stall and EX bubble insertion.

Parameters:
- NUM_SRC, 2, source operands per instruction (2..3).
- NUM_FWD, 2, forwarding source stages (1..4); stage 1 = nearest (EX/MEM).
- LOAD_LAT, 1, stall cycles required between a load in EX and a dependent instruction in ID (1..4).
- SELW, $clog2(NUM_FWD+1), width of one forward select (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ex_rs  in  NUM_SRC*5  EX-stage source regs; operand i at [5i+4:5i]
- ex_uses  in  NUM_SRC  EX operand i actually read (opcode-decoded upstream)
- id_rs  in  NUM_SRC*5  ID-stage source regs
- id_uses  in  NUM_SRC  ID operand i actually read
- id_rd  in  5  ID destination reg
- id_wr  in  1  ID instruction writes id_rd
- ex_rd  in  5  EX destination
- ex_wr  in  1  EX writes ex_rd
- ex_is_load  in  1  EX instruction is a load
- stg_rd  in  NUM_FWD*5  rd of stage k at [5(k-1)+4:5(k-1)]
- stg_wr  in  NUM_FWD  stage k writes its rd
- mc_issue  in  1  long-latency op leaves ID this cycle
- mc_rd  in  5  its destination
- mc_wb  in  1  long-latency result written back this cycle
- mc_wb_rd  in  5  writeback destination
- flush  in  1  squash ID/EX (branch mispredict)
- fwd_sel  out  NUM_SRC*SELW  per-operand select; 0 = regfile, k = stage k
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  insert NOP into ID/EX

Behaviour:
- Reset (rst=0 at rising edge): FSM → IDLE, cnt=0, pending[31:1]=0. While rst=0, all outputs are forced to 0.
- Forwarding (combinational):
  - Operand i selects the smallest k with stg_wr[k] & stg_rd_k!=0 & stg_rd_k==ex_rs_i & ex_uses[i]; else 0.
  - Youngest stage wins. x0 never forwards.
- Load-use detect: lu_hit = ex_is_load & ex_wr & ex_rd!=0 & any i (id_uses[i] & id_rs_i==ex_rd).
- FSM states IDLE and LU_STALL; cnt is 2 bits.
  - IDLE: lu_hit & !flush → stall_id=1 this cycle.
    - If LOAD_LAT>1: next LU_STALL, cnt=LOAD_LAT-1. Otherwise remain IDLE.
  - LU_STALL: stall_id=1 and cnt decrements each cycle; cnt==1 → IDLE next.
  - Total stall = exactly LOAD_LAT cycles.
- Scoreboard:
  - Next pending: set bit mc_rd on mc_issue (mc_rd!=0); clear bit mc_wb_rd on mc_wb.
  - Same reg issued and written back in one cycle: set wins.
  - Writeback to a non-pending reg: no effect. Bit 0 is never set.
- sb_hit = any i (id_uses[i] & pending[id_rs_i]) | (id_wr & pending[id_rd]) (RAW and WAW).
- Outputs:
  - stall_id = FSM stall | sb_hit.
  - bubble_ex = stall_id.
  - flush forces stall_id=0 and bubble_ex=0 in the same cycle.
- Flush:
  - Sends FSM → IDLE, cnt=0.
  - Does NOT clear pending, since in-flight mul/div still writes back.
- mc_issue is only asserted upstream when stall_id=0; the unit does not check this.
- fwd_sel remains valid during stalls.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_lu_stalls[31:0] and perf_sb_stalls[31:0].
  - Each increments on cycles where its source alone or jointly causes stall_id=1; both may increment in the same cycle.
  - Saturating at 32'hFFFF_FFFF; reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- NUM_FWD=2: stg_rd={x5,x5}, both stg_wr=1, ex_rs_0=x5, ex_uses=1 → fwd_sel_0=1. Drop stg_wr[1] → 2. ex_rs_0=x0 with stage rd x0 → 0.
- LOAD_LAT=3: load in EX with ex_rd=x7, ID uses id_rs_1=x7 → stall_id=1 for exactly 3 cycles, then 0. Operand with id_uses=0 → no stall.
- Flush during 2nd LU_STALL cycle → stall_id=0 same cycle, FSM IDLE next cycle, no residual stall.
- mc_issue rd=x10; ID reads x10 → stall until mc_wb rd=x10, then stall_id=0 next cycle. mc_issue and mc_wb both x10 in one cycle → bit stays set.
- WAW: pending x12, ID id_wr=1, id_rd=x12, no source use → stall_id=1.
- rst=0 mid-LU_STALL with pending x3 set → after release, stall_id=0 and an ID read of x3 does not stall. With HAZARD_PERF_EN: counters read 0 after reset and 3 after one LOAD_LAT=3 stall.
